// File: rtl/memory_sub_system_param.sv
// Cache/memory geometry shared by the direct-mapped cache controller and its storage.
package memory_sub_system_param;

  localparam int WORD_SIZE       = 32;
  localparam int CACHE_LINE_SIZE = 128;
  localparam int NUM_CACHE_LINES = 64;
  localparam int ADDR_LENGTH     = 16;
  localparam int INDEX_LENGTH    = 6;
  localparam int OFFSET_LENGTH   = 4;
  localparam int TAG_LENGTH      = ADDR_LENGTH - INDEX_LENGTH - OFFSET_LENGTH;
  localparam int WORDS_PER_LINE  = CACHE_LINE_SIZE / WORD_SIZE;

  typedef logic [TAG_LENGTH-1:0]      tag_t;
  typedef logic [INDEX_LENGTH-1:0]    index_t;
  typedef logic [CACHE_LINE_SIZE-1:0] line_t;
  typedef logic [WORD_SIZE-1:0]       word_t;
  typedef logic [$clog2(WORDS_PER_LINE)-1:0] word_sel_t;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE,
    WAIT_FILL
  } ctrl_state_t;

endpackage

// File: rtl/dm_cache_store.sv
// Tag/valid/dirty/data arrays: combinational read port, synchronous word-write and line-fill ports.
module dm_cache_store
  import memory_sub_system_param::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  index_t    rd_idx,
  output tag_t      rd_tag,
  output logic      rd_valid,
  output logic      rd_dirty,
  output line_t     rd_line,
  input  logic      wr_word_en,
  input  index_t    wr_idx,
  input  word_sel_t wr_word_sel,
  input  word_t     wr_word_data,
  input  logic      fill_en,
  input  index_t    fill_idx,
  input  tag_t      fill_tag,
  input  line_t     fill_line
);

  tag_t                       tag_mem  [NUM_CACHE_LINES];
  line_t                      data_mem [NUM_CACHE_LINES];
  logic [NUM_CACHE_LINES-1:0] valid_q;
  logic [NUM_CACHE_LINES-1:0] dirty_q;

  assign rd_tag   = tag_mem[rd_idx];
  assign rd_line  = data_mem[rd_idx];
  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
      dirty_q[fill_idx] <= 1'b0;
    end else if (wr_word_en) begin
      dirty_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless until the valid bit is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= fill_line;
    end else if (wr_word_en) begin
      data_mem[wr_idx][{wr_word_sel, 5'b0} +: WORD_SIZE] <= wr_word_data;
    end
  end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller with line-wide memory handshake
// and saturating hit/miss counters.
module dm_cache_ctrl
  import memory_sub_system_param::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cpu_req_valid,
  output logic                       cpu_req_ready,
  input  logic                       cpu_req_we,
  input  logic [ADDR_LENGTH-1:0]     cpu_req_addr,
  input  logic [WORD_SIZE-1:0]       cpu_req_wdata,
  output logic                       cpu_resp_valid,
  output logic [WORD_SIZE-1:0]       cpu_resp_rdata,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic                       mem_req_we,
  output logic [ADDR_LENGTH-1:0]     mem_req_addr,
  output logic [CACHE_LINE_SIZE-1:0] mem_req_wdata,
  input  logic                       mem_resp_valid,
  input  logic [CACHE_LINE_SIZE-1:0] mem_resp_rdata,
  output logic [CNT_WIDTH-1:0]       hit_count,
  output logic [CNT_WIDTH-1:0]       miss_count
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  ctrl_state_t state, state_nxt;

  logic                         req_we;
  logic [ADDR_LENGTH-1:0]       req_addr;
  word_t                        req_wdata;
  logic                         refill_q;
  logic [CNT_WIDTH-1:0]         hit_cnt_q;
  logic [CNT_WIDTH-1:0]         miss_cnt_q;

  tag_t      req_tag;
  index_t    req_idx;
  word_sel_t req_word;
  tag_t      rd_tag;
  logic      rd_valid;
  logic      rd_dirty;
  line_t     rd_line;
  logic      hit;
  logic      wr_word_en;
  logic      fill_en;
  logic      accept;
  logic      unused_addr_bits;

  assign req_tag  = req_addr[ADDR_LENGTH-1 -: TAG_LENGTH];
  assign req_idx  = req_addr[OFFSET_LENGTH +: INDEX_LENGTH];
  assign req_word = req_addr[3:2];
  assign unused_addr_bits = ^req_addr[1:0];

  assign hit           = rd_valid && (rd_tag == req_tag);
  assign cpu_req_ready = (state == IDLE);
  assign accept        = cpu_req_valid && cpu_req_ready;
  assign hit_count     = hit_cnt_q;
  assign miss_count    = miss_cnt_q;

  dm_cache_store u_store (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_idx       (req_idx),
    .rd_tag       (rd_tag),
    .rd_valid     (rd_valid),
    .rd_dirty     (rd_dirty),
    .rd_line      (rd_line),
    .wr_word_en   (wr_word_en),
    .wr_idx       (req_idx),
    .wr_word_sel  (req_word),
    .wr_word_data (req_wdata),
    .fill_en      (fill_en),
    .fill_idx     (req_idx),
    .fill_tag     (req_tag),
    .fill_line    (mem_resp_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      refill_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state <= state_nxt;
      // A hit reached through a refill is the tail of a miss, not a separate hit.
      if (state == COMPARE) begin
        if (hit) begin
          if (!refill_q) hit_cnt_q <= sat_inc(hit_cnt_q);
          refill_q <= 1'b0;
        end else begin
          miss_cnt_q <= sat_inc(miss_cnt_q);
          refill_q   <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      req_we    <= cpu_req_we;
      req_addr  <= cpu_req_addr;
      req_wdata <= cpu_req_wdata;
    end
  end

  always_comb begin
    state_nxt      = state;
    cpu_resp_valid = 1'b0;
    cpu_resp_rdata = '0;
    mem_req_valid  = 1'b0;
    mem_req_we     = 1'b0;
    mem_req_addr   = '0;
    mem_req_wdata  = '0;
    wr_word_en     = 1'b0;
    fill_en        = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          cpu_resp_valid = 1'b1;
          state_nxt      = IDLE;
          if (req_we) wr_word_en = 1'b1;
          else        cpu_resp_rdata = rd_line[{req_word, 5'b0} +: WORD_SIZE];
        end else if (rd_valid && rd_dirty) begin
          state_nxt = WRITEBACK;
        end else begin
          state_nxt = ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {rd_tag, req_idx, 4'h0};
        mem_req_wdata = rd_line;
        if (mem_req_ready) state_nxt = ALLOCATE;
      end
      ALLOCATE: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_tag, req_idx, 4'h0};
        if (mem_req_ready) state_nxt = WAIT_FILL;
      end
      WAIT_FILL: begin
        if (mem_resp_valid) begin
          fill_en   = 1'b1;
          state_nxt = COMPARE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
